read_write_logic: RTL and testbench
===================================

READ_WRITE_LOGIC -- requirements
Module: read_write_logic

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: rising-edge clock.
- reset, in, 1: synchronous active-high reset.
- chip_select_n, in, 1: active-low chip select.
- read_n, in, 1: active-low CPU read strobe.
- write_n, in, 1: active-low CPU write strobe.
- address, in, 1: A0.
- internal_data_bus, in, 8: write data from the bus buffer.
- buffer_enable, out, 1: 1 = buffer drives data_bus outward (read).
- write_data, out, 8: last latched write byte.
- write_icw1, write_icw2, write_icw3, write_icw4, out, 1 each: one-cycle commit pulses.
- write_ocw1, write_ocw2, write_ocw3, out, 1 each: one-cycle commit pulses.
- single_mode, out, 1: ICW1 bit D1.
- icw4_needed, out, 1: ICW1 bit D0.
- init_done, out, 1: 1 when in READY.

Function
REQ-003 wr_now SHALL be defined as ~chip_select_n & ~write_n & read_n; rd_now SHALL be defined as ~chip_select_n & ~read_n.
REQ-004 Each clock in which wr_now=1, write_data and the latched A0 SHALL capture internal_data_bus and address.
REQ-005 A write commit SHALL occur at the first edge where registered wr_active_q=1 and wr_now=0; the pulse SHALL be high for exactly one cycle after that edge.
REQ-006 Read SHALL take priority: if read_n and write_n are both low, no write SHALL be latched or committed.
REQ-007 buffer_enable SHALL equal registered rd_now, giving one-cycle latency on assert and deassert; it SHALL be 0 whenever wr_now was 1 in the prior cycle.
REQ-008 The init FSM SHALL have the states WAIT_ICW1, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4 and READY.
REQ-009 A commit with A0=0 and D4=1 SHALL be treated as ICW1 in any state, and SHALL:
- pulse write_icw1;
- latch single_mode and icw4_needed;
- go to WAIT_ICW2.
REQ-010 In WAIT_ICW2, a commit with A0=1 SHALL pulse write_icw2 and go to:
- WAIT_ICW3 if single_mode=0;
- else WAIT_ICW4 if icw4_needed=1;
- else READY.
REQ-011 In WAIT_ICW3, a commit with A0=1 SHALL pulse write_icw3 and go to WAIT_ICW4 if icw4_needed=1, else READY.
REQ-012 In WAIT_ICW4, a commit with A0=1 SHALL pulse write_icw4 and go to READY.
REQ-013 In READY, commits SHALL decode as follows:
- A0=1: write_ocw1.
- A0=0, D4=0, D3=0: write_ocw2.
- A0=0, D4=0, D3=1: write_ocw3.
REQ-014 In WAIT_ICW1–WAIT_ICW4, a commit with A0=0 and D4=0 SHALL be ignored: no pulse, no state change.
REQ-015 In WAIT_ICW1, any non-ICW1 commit SHALL be ignored.
REQ-016 At most one commit pulse SHALL be high in any cycle.
REQ-017 Deasserting chip_select_n while write_n is low SHALL count as write deassertion and commit the latched data.

Reset
REQ-018 On reset=1 at a clock edge, the following SHALL be cleared:
- FSM to WAIT_ICW1;
- wr_active_q to 0;
- all pulses to 0;
- buffer_enable to 0;
- write_data to 8'h00;
- single_mode, icw4_needed and init_done to 0.
REQ-019 Reset asserted mid-write SHALL suppress that commit; a strobe still low after reset releases SHALL commit normally on its later deassertion.

Configuration
REQ-020 With the macro RW_SYNC_STAGE_EN defined, chip_select_n, read_n, write_n and address SHALL pass through a two-flop synchronizer, reset to 1/1/1/0, before all logic.
REQ-021 With RW_SYNC_STAGE_EN defined, all latencies SHALL increase by two cycles, and internal_data_bus SHALL be delayed two cycles to stay aligned.
REQ-022 Without RW_SYNC_STAGE_EN, the inputs SHALL be used directly with the latencies stated above.

Verification
REQ-023 Reset, then ICW1=8'h13 (A0=0) followed by ICW2=8'h20 (A0=1) -> write_icw1 then write_icw2 single pulses; ICW3 skipped; next A0=1 write 8'h01 -> write_icw4; init_done=1.
REQ-024 ICW1=8'h10 -> ICW2 -> ICW3 -> READY without ICW4; A0=0 writes 8'h20 -> write_ocw2 and 8'h0A -> write_ocw3; A0=1 8'hFF -> write_ocw1, write_data=8'hFF.
REQ-025 read_n low for 3 cycles with chip_select_n=0 -> buffer_enable high for 3 cycles starting one cycle late; read_n and write_n both low -> no commit pulse.
REQ-026 In WAIT_ICW2, A0=0 write 8'h08 -> no pulse, state unchanged; a fresh ICW1 in READY -> FSM back to WAIT_ICW2, init_done=0.
REQ-027 reset pulsed while write_n is low -> no commit pulse; with RW_SYNC_STAGE_EN defined, the REQ-023 sequence -> pulses appear two cycles later.

Source files
------------

// File: rtl/read_write_logic.sv
// CPU read/write strobe decoder and ICW/OCW init sequencer.
// Define RW_SYNC_STAGE_EN to add a 2-flop input synchronizer.
module read_write_logic (
  input  logic       clk,
  input  logic       reset,
  input  logic       chip_select_n,
  input  logic       read_n,
  input  logic       write_n,
  input  logic       address,
  input  logic [7:0] internal_data_bus,
  output logic       buffer_enable,
  output logic [7:0] write_data,
  output logic       write_icw1,
  output logic       write_icw2,
  output logic       write_icw3,
  output logic       write_icw4,
  output logic       write_ocw1,
  output logic       write_ocw2,
  output logic       write_ocw3,
  output logic       single_mode,
  output logic       icw4_needed,
  output logic       init_done
);

  typedef enum logic [2:0] {
    WAIT_ICW1,
    WAIT_ICW2,
    WAIT_ICW3,
    WAIT_ICW4,
    READY
  } state_t;

  state_t     state;
  logic       cs_n_s;
  logic       rd_n_s;
  logic       wr_n_s;
  logic       a0_s;
  logic [7:0] data_s;

`ifdef RW_SYNC_STAGE_EN
  logic [1:0] cs_sq;
  logic [1:0] rd_sq;
  logic [1:0] wr_sq;
  logic [1:0] a0_sq;
  logic [7:0] data_q1;
  logic [7:0] data_q2;

  // Data rides alongside the strobes so it stays aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sq   <= 2'b11;
      rd_sq   <= 2'b11;
      wr_sq   <= 2'b11;
      a0_sq   <= 2'b00;
      data_q1 <= 8'h00;
      data_q2 <= 8'h00;
    end else begin
      cs_sq   <= {cs_sq[0], chip_select_n};
      rd_sq   <= {rd_sq[0], read_n};
      wr_sq   <= {wr_sq[0], write_n};
      a0_sq   <= {a0_sq[0], address};
      data_q1 <= internal_data_bus;
      data_q2 <= data_q1;
    end
  end

  assign cs_n_s = cs_sq[1];
  assign rd_n_s = rd_sq[1];
  assign wr_n_s = wr_sq[1];
  assign a0_s   = a0_sq[1];
  assign data_s = data_q2;
`else
  assign cs_n_s = chip_select_n;
  assign rd_n_s = read_n;
  assign wr_n_s = write_n;
  assign a0_s   = address;
  assign data_s = internal_data_bus;
`endif

  logic wr_now;
  logic rd_now;
  logic both_low;
  logic wr_active_q;
  logic a0_q;
  logic commit;
  logic is_icw1;

  assign wr_now   = ~cs_n_s & ~wr_n_s & rd_n_s;
  assign rd_now   = ~cs_n_s & ~rd_n_s;
  assign both_low = rd_now & ~wr_n_s;
  assign commit   = wr_active_q & ~wr_now & ~both_low;
  assign is_icw1  = ~a0_q & write_data[4];

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= WAIT_ICW1;
      wr_active_q   <= 1'b0;
      a0_q          <= 1'b0;
      buffer_enable <= 1'b0;
      write_data    <= 8'h00;
      single_mode   <= 1'b0;
      icw4_needed   <= 1'b0;
      init_done     <= 1'b0;
      write_icw1    <= 1'b0;
      write_icw2    <= 1'b0;
      write_icw3    <= 1'b0;
      write_icw4    <= 1'b0;
      write_ocw1    <= 1'b0;
      write_ocw2    <= 1'b0;
      write_ocw3    <= 1'b0;
    end else begin
      write_icw1    <= 1'b0;
      write_icw2    <= 1'b0;
      write_icw3    <= 1'b0;
      write_icw4    <= 1'b0;
      write_ocw1    <= 1'b0;
      write_ocw2    <= 1'b0;
      write_ocw3    <= 1'b0;
      wr_active_q   <= wr_now;
      buffer_enable <= rd_now;
      if (wr_now) begin
        write_data <= data_s;
        a0_q       <= a0_s;
      end
      if (commit) begin
        if (is_icw1) begin
          write_icw1  <= 1'b1;
          single_mode <= write_data[1];
          icw4_needed <= write_data[0];
          init_done   <= 1'b0;
          state       <= WAIT_ICW2;
        end else begin
          unique case (state)
            WAIT_ICW2: begin
              if (a0_q) begin
                write_icw2 <= 1'b1;
                if (!single_mode) begin
                  state <= WAIT_ICW3;
                end else if (icw4_needed) begin
                  state <= WAIT_ICW4;
                end else begin
                  state     <= READY;
                  init_done <= 1'b1;
                end
              end
            end
            WAIT_ICW3: begin
              if (a0_q) begin
                write_icw3 <= 1'b1;
                if (icw4_needed) begin
                  state <= WAIT_ICW4;
                end else begin
                  state     <= READY;
                  init_done <= 1'b1;
                end
              end
            end
            WAIT_ICW4: begin
              if (a0_q) begin
                write_icw4 <= 1'b1;
                state      <= READY;
                init_done  <= 1'b1;
              end
            end
            READY: begin
              if (a0_q) begin
                write_ocw1 <= 1'b1;
              end else if (write_data[3]) begin
                write_ocw3 <= 1'b1;
              end else begin
                write_ocw2 <= 1'b1;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_read_write_logic.sv
// Scoreboard bench for read_write_logic with a queue-based init model.
module tb_read_write_logic;

`ifdef RW_SYNC_STAGE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       chip_select_n = 1'b1;
  logic       read_n = 1'b1;
  logic       write_n = 1'b1;
  logic       address = 1'b0;
  logic [7:0] internal_data_bus = 8'h00;
  logic       buffer_enable;
  logic [7:0] write_data;
  logic       write_icw1, write_icw2, write_icw3, write_icw4;
  logic       write_ocw1, write_ocw2, write_ocw3;
  logic       single_mode, icw4_needed, init_done;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  read_write_logic dut (
    .clk(clk),
    .reset(reset),
    .chip_select_n(chip_select_n),
    .read_n(read_n),
    .write_n(write_n),
    .address(address),
    .internal_data_bus(internal_data_bus),
    .buffer_enable(buffer_enable),
    .write_data(write_data),
    .write_icw1(write_icw1),
    .write_icw2(write_icw2),
    .write_icw3(write_icw3),
    .write_icw4(write_icw4),
    .write_ocw1(write_ocw1),
    .write_ocw2(write_ocw2),
    .write_ocw3(write_ocw3),
    .single_mode(single_mode),
    .icw4_needed(icw4_needed),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  // {pulses[6:0], data[7:0], init_done, single_mode, icw4_needed}
  logic [17:0] exp_q[$];

  // Reference model: ICW1 schedules the list of ICWs still owed.
  bit m_seen;
  bit m_sm;
  bit m_ic4;
  int m_pending[$];

  task automatic model_reset();
    m_seen = 0;
    m_sm = 0;
    m_ic4 = 0;
    m_pending.delete();
  endtask

  task automatic model_write(input bit a0, input logic [7:0] d);
    int idx;
    logic [6:0] pv;
    bit rdy;
    idx = -1;
    if (!a0 && d[4]) begin
      m_seen = 1;
      m_sm = d[1];
      m_ic4 = d[0];
      m_pending.delete();
      m_pending.push_back(2);
      if (!m_sm) m_pending.push_back(3);
      if (m_ic4) m_pending.push_back(4);
      idx = 0;
    end else if (!m_seen) begin
      idx = -1;
    end else if (m_pending.size() != 0) begin
      if (a0) idx = m_pending.pop_front() - 1;
    end else begin
      idx = a0 ? 4 : (d[3] ? 6 : 5);
    end
    if (idx >= 0) begin
      pv = 7'd1 << idx;
      rdy = m_seen && (m_pending.size() == 0);
      exp_q.push_back({pv, d, rdy, m_sm, m_ic4});
    end
  endtask

  function automatic logic [6:0] pulses();
    return {write_ocw3, write_ocw2, write_ocw1, write_icw4,
            write_icw3, write_icw2, write_icw1};
  endfunction

  // Monitor: pops an expectation whenever a commit pulse shows up.
  initial begin
    logic [17:0] e;
    logic [6:0] p;
    wait (mon_en);
    forever begin
      @(posedge clk);
      #1;
      p = pulses();
      if ($countones(p) > 1) begin
        errors++;
        $display("FAIL onehot: pulses=%b", p);
      end
      if (p != 7'd0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious: pulses=%b data=%h", p, write_data);
        end else begin
          e = exp_q.pop_front();
          if ({p, write_data, init_done, single_mode, icw4_needed} != e) begin
            errors++;
            $display("FAIL commit: got p=%b d=%h id/sm/i4=%b%b%b exp p=%b d=%h id/sm/i4=%b",
                     p, write_data, init_done, single_mode, icw4_needed,
                     e[17:11], e[10:3], e[2:0]);
          end
        end
      end
    end
  end

  task automatic do_write(input bit a0, input logic [7:0] d, input bit cs_rel);
    model_write(a0, d);
    @(negedge clk);
    chip_select_n = 0;
    write_n = 0;
    address = a0;
    internal_data_bus = d;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    if (cs_rel) begin
      chip_select_n = 1;
      @(negedge clk);
      write_n = 1;
    end else begin
      write_n = 1;
      @(negedge clk);
      chip_select_n = 1;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic check_eq(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h exp %h", name, act, exp);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
    check_eq("rst_pulses", {25'd0, pulses()}, 0);
    check_eq("rst_wdata", {24'd0, write_data}, 0);
    check_eq("rst_flags", {28'd0, buffer_enable, single_mode, icw4_needed, init_done}, 0);
    mon_en = 1;

    // ICW1 with SNGL and IC4, ICW3 skipped
    do_write(0, 8'h13, 0);
    do_write(1, 8'h20, 0);
    check_eq("init_pre_icw4", {31'd0, init_done}, 0);
    do_write(1, 8'h01, 1);
    check_eq("init_done_a", {31'd0, init_done}, 1);

    // Cascade, no ICW4, then OCWs
    do_write(0, 8'h10, 0);
    check_eq("init_cleared", {31'd0, init_done}, 0);
    do_write(1, 8'h20, 0);
    do_write(1, 8'h04, 0);
    check_eq("init_done_b", {31'd0, init_done}, 1);
    do_write(0, 8'h20, 0);
    do_write(0, 8'h0A, 1);
    do_write(1, 8'hFF, 0);
    check_eq("wdata_ff", {24'd0, write_data}, 32'hFF);

    // Read: buffer_enable follows after LAT cycles for 3 cycles
    @(negedge clk);
    chip_select_n = 0;
    read_n = 0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("buf_en_%0d", k), {31'd0, buffer_enable},
               {31'd0, (k >= LAT && k < LAT + 3)});
      @(negedge clk);
      if (k == 3) begin
        read_n = 1;
        chip_select_n = 1;
      end
    end

    // Read and write both low: no commit
    @(negedge clk);
    chip_select_n = 0;
    read_n = 0;
    write_n = 0;
    address = 1;
    internal_data_bus = 8'h55;
    repeat (3) @(negedge clk);
    chip_select_n = 1;
    read_n = 1;
    write_n = 1;
    repeat (6) @(negedge clk);

    // Ignored A0=0/D4=0 in WAIT_ICW2, then re-init from READY
    do_write(0, 8'h12, 0);
    do_write(0, 8'h08, 0);
    check_eq("init_w2", {31'd0, init_done}, 0);
    do_write(1, 8'h40, 0);
    check_eq("init_done_c", {31'd0, init_done}, 1);
    do_write(0, 8'h16, 0);
    check_eq("reinit", {31'd0, init_done}, 0);

    // Reset mid-write, strobe released during reset: no commit
    @(negedge clk);
    chip_select_n = 0;
    write_n = 0;
    address = 0;
    internal_data_bus = 8'h13;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    write_n = 1;
    chip_select_n = 1;
    @(negedge clk);
    reset = 0;
    model_reset();
    repeat (6) @(negedge clk);
    check_eq("rst_mid_flags", {29'd0, init_done, single_mode, icw4_needed}, 0);

    // Reset mid-write, strobe held after release: commits normally
    @(negedge clk);
    chip_select_n = 0;
    write_n = 0;
    address = 0;
    internal_data_bus = 8'h11;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    model_reset();
    model_write(0, 8'h11);
    repeat (3) @(negedge clk);
    write_n = 1;
    chip_select_n = 1;
    repeat (6) @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      logic [7:0] d;
      bit a;
      d = 8'($urandom);
      a = 1'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        a = 0;
        d[4] = 1;
      end
      do_write(a, d, 1'($urandom));
    end

    repeat (10) @(negedge clk);
    check_eq("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
